// File: rtl/if_fetch_if.sv
// Memory-port bundle between the fetch stage and the memory arbiter.
// Latency: read byte returns on mem_din_i the cycle after an accepted request (mem_rd_o & mem_gnt_i).
// Backpressure: mem_gnt_i low means the request is not taken; the master holds and reissues it.
// Ports: mem_rd_o/mem_addr_o request from fetch; mem_gnt_i grant and mem_din_i read data from arbiter.
interface if_fetch_if;
   logic        mem_rd_o;
   logic [31:0] mem_addr_o;
   logic        mem_gnt_i;
   logic [7:0]  mem_din_i;

   modport master (
      output mem_rd_o,
      output mem_addr_o,
      input  mem_gnt_i,
      input  mem_din_i
   );

   modport slave (
      input  mem_rd_o,
      input  mem_addr_o,
      output mem_gnt_i,
      output mem_din_i
   );
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch: owns the PC and a direct-mapped one-word-per-line I-cache, fills misses over a byte-wide port.
// Latency: cache hit -> 1 cycle; miss with continuous grant -> 5 cycles from miss start to inst_valid_o.
// Backpressure: stall_i holds pc_o/inst_o/inst_valid_o; no lookup starts until the output slot frees.
// Ports: clk, rst (async active-low); stall_i; branchFlag_i/branchTarget_i redirect from decode;
//        mem (if_fetch_if.master) byte memory port; pc_o/inst_o/inst_valid_o one-entry output register.
module if_fetch #(
   parameter int ICACHE_IDX_W = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_i,
   input  logic        branchFlag_i,
   input  logic [31:0] branchTarget_i,
   if_fetch_if.master  mem,
   output logic [31:0] pc_o,
   output logic [31:0] inst_o,
   output logic        inst_valid_o
);

   localparam int LINES = 1 << ICACHE_IDX_W;
   localparam int TAG_W = 32 - ICACHE_IDX_W - 2;

   typedef enum logic {IDLE, FETCH} state_t;

   state_t                  state;
   logic [31:0]             fetch_pc;
   logic [2:0]              ic;        // bytes requested and accepted
   logic [2:0]              rc;        // bytes received
   logic [23:0]             wbuf;      // lower three bytes of the word being assembled
   logic                    pend;      // a byte accepted last cycle arrives this cycle
   logic                    drop;      // that byte was accepted in a redirect cycle: ignore it

   logic [LINES-1:0]        line_vld;
   logic [TAG_W-1:0]        line_tag [LINES];
   logic [31:0]             line_dat [LINES];

   logic [ICACHE_IDX_W-1:0] idx;
   logic [TAG_W-1:0]        tag;
   logic                    hit;
   logic                    slot_free;
   logic                    issue;
   logic                    accept;
   logic                    recv;
   logic                    done;
   logic                    fill;
   logic [31:0]             new_word;
   logic                    unused_tgt;

   assign unused_tgt = ^branchTarget_i[1:0];

   always_comb begin
      idx       = fetch_pc[ICACHE_IDX_W+1:2];
      tag       = fetch_pc[31:ICACHE_IDX_W+2];
      hit       = line_vld[idx] && (line_tag[idx] == tag);
      slot_free = !inst_valid_o || !stall_i;
      issue     = (state == FETCH) && !ic[2];
      accept    = issue && mem.mem_gnt_i;
      recv      = (state == FETCH) && pend && !drop;
      done      = recv && (rc == 3'd3);
      fill      = done && !branchFlag_i;
      new_word  = {mem.mem_din_i, wbuf};
   end

   // Request outputs derive from state/counters only, so the redirect input
   // has no combinational path onto the memory bus; a byte granted in the
   // redirect cycle is instead discarded through the drop flag.
   always_comb begin
      mem.mem_rd_o   = issue;
      mem.mem_addr_o = issue ? (fetch_pc + {29'd0, ic}) : 32'd0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         fetch_pc     <= 32'd0;
         ic           <= 3'd0;
         rc           <= 3'd0;
         wbuf         <= 24'd0;
         pend         <= 1'b0;
         drop         <= 1'b0;
         line_vld     <= '0;
         pc_o         <= 32'd0;
         inst_o       <= 32'd0;
         inst_valid_o <= 1'b0;
      end else begin
         pend <= accept;
         drop <= accept && branchFlag_i;
         if (branchFlag_i) begin
            fetch_pc     <= {branchTarget_i[31:2], 2'b00};
            inst_valid_o <= 1'b0;
            state        <= IDLE;
            ic           <= 3'd0;
            rc           <= 3'd0;
            wbuf         <= 24'd0;
         end else begin
            case (state)
               IDLE: begin
                  if (slot_free) begin
                     if (hit) begin
                        pc_o         <= fetch_pc;
                        inst_o       <= line_dat[idx];
                        inst_valid_o <= 1'b1;
                        fetch_pc     <= fetch_pc + 32'd4;
                     end else begin
                        state        <= FETCH;
                        ic           <= 3'd0;
                        rc           <= 3'd0;
                        wbuf         <= 24'd0;
                        inst_valid_o <= 1'b0;
                     end
                  end
               end
               FETCH: begin
                  if (accept) begin
                     ic <= ic + 3'd1;
                  end
                  if (recv) begin
                     if (done) begin
                        line_vld[idx] <= 1'b1;
                        pc_o          <= fetch_pc;
                        inst_o        <= new_word;
                        inst_valid_o  <= 1'b1;
                        fetch_pc      <= fetch_pc + 32'd4;
                        state         <= IDLE;
                        ic            <= 3'd0;
                        rc            <= 3'd0;
                     end else begin
                        case (rc[1:0])
                           2'd0:    wbuf[7:0]   <= mem.mem_din_i;
                           2'd1:    wbuf[15:8]  <= mem.mem_din_i;
                           default: wbuf[23:16] <= mem.mem_din_i;
                        endcase
                        rc <= rc + 3'd1;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   // Tag/data arrays need no reset: the valid bits gate every use.
   always_ff @(posedge clk) begin
      if (fill) begin
         line_tag[idx] <= tag;
         line_dat[idx] <= new_word;
      end
   end

endmodule

// File: tb/tb_if_fetch.sv
module tb_if_fetch;
   logic        clk;
   logic        rst;
   logic        stall;
   logic        branch;
   logic [31:0] target;
   logic [31:0] pc;
   logic [31:0] inst;
   logic        valid;

   int checks;
   int passed;

   logic [7:0]  mem [512];
   logic [31:0] acc_q [$];

   if_fetch_if bus ();

   if_fetch #(.ICACHE_IDX_W(5)) dut (
      .clk            (clk),
      .rst            (rst),
      .stall_i        (stall),
      .branchFlag_i   (branch),
      .branchTarget_i (target),
      .mem            (bus),
      .pc_o           (pc),
      .inst_o         (inst),
      .inst_valid_o   (valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Byte memory: data for an accepted request appears the next cycle.
   always @(posedge clk) begin
      bus.mem_din_i <= (bus.mem_rd_o && bus.mem_gnt_i) ? mem[bus.mem_addr_o[8:0]] : 8'h00;
      if (bus.mem_rd_o && bus.mem_gnt_i) acc_q.push_back(bus.mem_addr_o);
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      logic [97:0] got;
      rst = 1'b0;
      repeat (2) tick();
      got = {bus.mem_rd_o, bus.mem_addr_o, valid, pc, inst};
      checks++;
      if (got !== 98'd0) $display("FAIL reset_outputs got=%h exp=0", got);
      else passed++;
   endtask

   task automatic test_cold_miss;
      int lat;
      logic [127:0] got_a;
      logic [64:0]  got;
      rst = 1'b1;
      checks++;
      if (bus.mem_rd_o !== 1'b0) $display("FAIL idle_no_req got=%b exp=0", bus.mem_rd_o);
      else passed++;
      acc_q.delete();
      tick();
      checks++;
      if ({bus.mem_rd_o, bus.mem_addr_o} !== {1'b1, 32'd0}) $display("FAIL cold_first_req got=%b/%h exp=1/0", bus.mem_rd_o, bus.mem_addr_o);
      else passed++;
      lat = 0;
      while (!valid && lat < 20) begin tick(); lat++; end
      checks++;
      if (lat !== 5) $display("FAIL cold_latency got=%0d exp=5", lat);
      else passed++;
      got = {valid, pc, inst};
      checks++;
      if (got !== {1'b1, 32'd0, 32'h00a00513}) $display("FAIL cold_word got=%h exp=%h", got, {1'b1, 32'd0, 32'h00a00513});
      else passed++;
      got_a = (acc_q.size() == 4) ? {acc_q[0], acc_q[1], acc_q[2], acc_q[3]} : '1;
      checks++;
      if (got_a !== {32'd0, 32'd1, 32'd2, 32'd3}) $display("FAIL cold_addrs got=%h exp=0,1,2,3", got_a);
      else passed++;
   endtask

   task automatic test_branch_hit;
      logic [64:0] got;
      branch = 1'b1;
      target = 32'd0;
      stall  = 1'b0;
      acc_q.delete();
      tick();
      branch = 1'b0;
      checks++;
      if ({valid, bus.mem_rd_o} !== 2'b00) $display("FAIL redirect_clears got=%b exp=00", {valid, bus.mem_rd_o});
      else passed++;
      tick();
      got = {valid, pc, inst};
      checks++;
      if (got !== {1'b1, 32'd0, 32'h00a00513}) $display("FAIL hit_word got=%h exp=%h", got, {1'b1, 32'd0, 32'h00a00513});
      else passed++;
      checks++;
      if (acc_q.size() !== 0) $display("FAIL hit_no_mem got=%0d exp=0", acc_q.size());
      else passed++;
   endtask

   task automatic test_stall;
      int lat;
      logic [65:0]  got_h;
      logic [64:0]  got;
      logic [127:0] got_a;
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         got_h = {valid, pc, inst, bus.mem_rd_o};
         checks++;
         if (got_h !== {1'b1, 32'd0, 32'h00a00513, 1'b0}) $display("FAIL stall_hold%0d got=%h exp=%h", i, got_h, {1'b1, 32'd0, 32'h00a00513, 1'b0});
         else passed++;
      end
      stall = 1'b0;
      acc_q.delete();
      tick();
      checks++;
      if ({valid, bus.mem_rd_o, bus.mem_addr_o} !== {1'b0, 1'b1, 32'd4}) $display("FAIL stall_release_req got=%b/%b/%h exp=0/1/4", valid, bus.mem_rd_o, bus.mem_addr_o);
      else passed++;
      lat = 0;
      while (!valid && lat < 20) begin tick(); lat++; end
      got = {valid, pc, inst};
      checks++;
      if ((lat !== 5) || (got !== {1'b1, 32'd4, 32'h07060504})) $display("FAIL pc4_word lat=%0d got=%h exp lat=5 %h", lat, got, {1'b1, 32'd4, 32'h07060504});
      else passed++;
      got_a = (acc_q.size() == 4) ? {acc_q[0], acc_q[1], acc_q[2], acc_q[3]} : '1;
      checks++;
      if (got_a !== {32'd4, 32'd5, 32'd6, 32'd7}) $display("FAIL pc4_addrs got=%h exp=4,5,6,7", got_a);
      else passed++;
   endtask

   task automatic test_gnt_gap;
      int lat;
      int n10;
      bit denied;
      logic [64:0]  got;
      logic [127:0] got_a;
      stall = 1'b0;
      acc_q.delete();
      tick();
      lat = 0;
      n10 = 0;
      denied = 1'b0;
      while (!valid && lat < 20) begin
         bus.mem_gnt_i = 1'b1;
         if (bus.mem_rd_o && bus.mem_addr_o == 32'd10) begin
            n10++;
            if (!denied) begin bus.mem_gnt_i = 1'b0; denied = 1'b1; end
         end
         tick();
         lat++;
      end
      bus.mem_gnt_i = 1'b1;
      checks++;
      if (lat !== 6) $display("FAIL gap_latency got=%0d exp=6", lat);
      else passed++;
      checks++;
      if (n10 !== 2) $display("FAIL gap_reissue got=%0d exp=2", n10);
      else passed++;
      got = {valid, pc, inst};
      checks++;
      if (got !== {1'b1, 32'd8, 32'h0b0a0908}) $display("FAIL gap_word got=%h exp=%h", got, {1'b1, 32'd8, 32'h0b0a0908});
      else passed++;
      got_a = (acc_q.size() == 4) ? {acc_q[0], acc_q[1], acc_q[2], acc_q[3]} : '1;
      checks++;
      if (got_a !== {32'd8, 32'd9, 32'd10, 32'd11}) $display("FAIL gap_addrs got=%h exp=8,9,a,b", got_a);
      else passed++;
   endtask

   task automatic test_redirect;
      int lat;
      logic [64:0] got;
      tick();
      checks++;
      if ({bus.mem_rd_o, bus.mem_addr_o} !== {1'b1, 32'd12}) $display("FAIL rd_fetch12 got=%b/%h exp=1/c", bus.mem_rd_o, bus.mem_addr_o);
      else passed++;
      repeat (3) tick();
      branch = 1'b1;
      target = 32'h102;
      tick();
      branch = 1'b0;
      checks++;
      if ({valid, bus.mem_rd_o} !== 2'b00) $display("FAIL rd_clears got=%b exp=00", {valid, bus.mem_rd_o});
      else passed++;
      tick();
      checks++;
      if ({bus.mem_rd_o, bus.mem_addr_o} !== {1'b1, 32'h100}) $display("FAIL rd_new_req got=%b/%h exp=1/100", bus.mem_rd_o, bus.mem_addr_o);
      else passed++;
      lat = 0;
      while (!valid && lat < 20) begin tick(); lat++; end
      got = {valid, pc, inst};
      checks++;
      if ((lat !== 5) || (got !== {1'b1, 32'h100, 32'h03020100})) $display("FAIL rd_word lat=%0d got=%h exp lat=5 %h", lat, got, {1'b1, 32'h100, 32'h03020100});
      else passed++;
      branch = 1'b1;
      target = 32'd12;
      tick();
      branch = 1'b0;
      tick();
      checks++;
      if ({valid, bus.mem_rd_o, bus.mem_addr_o} !== {1'b0, 1'b1, 32'd12}) $display("FAIL rd_no_line12 got=%b/%b/%h exp=0/1/c", valid, bus.mem_rd_o, bus.mem_addr_o);
      else passed++;
   endtask

   task automatic test_reset_mid_fetch;
      int lat;
      logic [97:0] got_r;
      logic [64:0] got;
      repeat (2) tick();
      rst = 1'b0;
      #1;
      got_r = {bus.mem_rd_o, bus.mem_addr_o, valid, pc, inst};
      checks++;
      if (got_r !== 98'd0) $display("FAIL async_reset got=%h exp=0", got_r);
      else passed++;
      tick();
      rst = 1'b1;
      acc_q.delete();
      tick();
      checks++;
      if ({bus.mem_rd_o, bus.mem_addr_o} !== {1'b1, 32'd0}) $display("FAIL rst_cache_invalid got=%b/%h exp=1/0", bus.mem_rd_o, bus.mem_addr_o);
      else passed++;
      lat = 0;
      while (!valid && lat < 20) begin tick(); lat++; end
      got = {valid, pc, inst};
      checks++;
      if ((lat !== 5) || (got !== {1'b1, 32'd0, 32'h00a00513})) $display("FAIL rst_refetch lat=%0d got=%h exp lat=5 %h", lat, got, {1'b1, 32'd0, 32'h00a00513});
      else passed++;
   endtask

   task automatic test_wrap;
      int lat;
      logic [64:0] got;
      branch = 1'b1;
      target = 32'hffff_ffff;
      tick();
      branch = 1'b0;
      tick();
      checks++;
      if ({valid, bus.mem_rd_o, bus.mem_addr_o} !== {1'b0, 1'b1, 32'hffff_fffc}) $display("FAIL wrap_req got=%b/%b/%h exp=0/1/fffffffc", valid, bus.mem_rd_o, bus.mem_addr_o);
      else passed++;
      lat = 0;
      while (!valid && lat < 20) begin tick(); lat++; end
      got = {valid, pc, inst};
      checks++;
      if ((lat !== 5) || (got !== {1'b1, 32'hffff_fffc, 32'hfffefdfc})) $display("FAIL wrap_word lat=%0d got=%h exp lat=5 %h", lat, got, {1'b1, 32'hffff_fffc, 32'hfffefdfc});
      else passed++;
      tick();
      got = {valid, pc, inst};
      checks++;
      if (got !== {1'b1, 32'd0, 32'h00a00513}) $display("FAIL wrap_to_zero_hit got=%h exp=%h", got, {1'b1, 32'd0, 32'h00a00513});
      else passed++;
   endtask

   initial begin
      checks = 0;
      passed = 0;
      rst    = 1'b0;
      stall  = 1'b0;
      branch = 1'b0;
      target = 32'd0;
      bus.mem_gnt_i = 1'b1;
      for (int i = 0; i < 512; i++) mem[i] = i[7:0];
      mem[0] = 8'h13;
      mem[1] = 8'h05;
      mem[2] = 8'ha0;
      mem[3] = 8'h00;

      test_reset();
      test_cold_miss();
      test_branch_hit();
      test_stall();
      test_gnt_gap();
      test_redirect();
      test_reset_mid_fetch();
      test_wrap();

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
